// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle types for the multi-cycle RV32IM control unit.
package ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [6:0] F7_M     = 7'b0000001;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    typedef enum logic [3:0] {
        ALU_AND    = 4'd0,
        ALU_OR     = 4'd1,
        ALU_XOR    = 4'd2,
        ALU_ADD    = 4'd3,
        ALU_SUB    = 4'd4,
        ALU_MUL    = 4'd5,
        ALU_MULH   = 4'd6,
        ALU_MULHSU = 4'd7,
        ALU_SLL    = 4'd8,
        ALU_SRL    = 4'd9,
        ALU_SRA    = 4'd10,
        ALU_MULHU  = 4'd11,
        ALU_SLT    = 4'd12,
        ALU_SLTU   = 4'd13,
        ALU_DIV    = 4'd14,
        ALU_REM    = 4'd15
    } aluop_t;

    localparam logic [1:0] SRC_RS2   = 2'b00;
    localparam logic [1:0] SRC_IMM12 = 2'b01;
    localparam logic [1:0] SRC_IMM20 = 2'b10;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_IMM20 = 2'b01;
    localparam logic [1:0] SEL_ALU   = 2'b10;
    localparam logic [1:0] SEL_GPIO  = 2'b11;

    typedef struct packed {
        logic [1:0] alusrc;
        aluop_t     aluop;
        logic [1:0] regsel;
        logic       regwrite;
        logic       gpio_we;
        logic       div_signed;
        logic       illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '{
        alusrc:     SRC_RS2,
        aluop:      ALU_AND,
        regsel:     SEL_NONE,
        regwrite:   1'b0,
        gpio_we:    1'b0,
        div_signed: 1'b0,
        illegal:    1'b0
    };

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction-field decoder producing the EX control bundle.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter logic [11:0] CSR_GPIO_OUT = 12'hF00,
    parameter logic [11:0] CSR_GPIO_IN  = 12'hF02,
    parameter bit          ENABLE_M     = 1'b1
) (
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic [11:0]  imm12,
    output ctrl_bundle_t ctrl_c,
    output logic         is_div_c
);

    logic legal;

    always_comb begin
        ctrl_c   = BUBBLE;
        is_div_c = 1'b0;
        legal    = 1'b1;
        case (op)
            OP_R: begin
                ctrl_c.alusrc   = SRC_RS2;
                ctrl_c.regsel   = SEL_ALU;
                ctrl_c.regwrite = 1'b1;
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  ctrl_c.aluop = ALU_ADD;
                            3'b001:  ctrl_c.aluop = ALU_SLL;
                            3'b010:  ctrl_c.aluop = ALU_SLT;
                            3'b011:  ctrl_c.aluop = ALU_SLTU;
                            3'b100:  ctrl_c.aluop = ALU_XOR;
                            3'b101:  ctrl_c.aluop = ALU_SRL;
                            3'b110:  ctrl_c.aluop = ALU_OR;
                            default: ctrl_c.aluop = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000)      ctrl_c.aluop = ALU_SUB;
                        else if (funct3 == 3'b101) ctrl_c.aluop = ALU_SRA;
                        else                       legal = 1'b0;
                    end
                    F7_M: begin
                        if (ENABLE_M) begin
                            case (funct3)
                                3'b000:  ctrl_c.aluop = ALU_MUL;
                                3'b001:  ctrl_c.aluop = ALU_MULH;
                                3'b010:  ctrl_c.aluop = ALU_MULHSU;
                                3'b011:  ctrl_c.aluop = ALU_MULHU;
                                3'b100:  ctrl_c.aluop = ALU_DIV;
                                3'b101:  ctrl_c.aluop = ALU_DIV;
                                3'b110:  ctrl_c.aluop = ALU_REM;
                                default: ctrl_c.aluop = ALU_REM;
                            endcase
                            // funct3[2] marks the divider ops; funct3[0] marks the unsigned ones
                            is_div_c          = funct3[2];
                            ctrl_c.div_signed = funct3[2] & ~funct3[0];
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_I: begin
                ctrl_c.alusrc   = SRC_IMM12;
                ctrl_c.regsel   = SEL_ALU;
                ctrl_c.regwrite = 1'b1;
                case (funct3)
                    3'b000: ctrl_c.aluop = ALU_ADD;
                    3'b001: ctrl_c.aluop = ALU_SLL;
                    3'b010: ctrl_c.aluop = ALU_SLT;
                    3'b011: ctrl_c.aluop = ALU_SLTU;
                    3'b100: ctrl_c.aluop = ALU_XOR;
                    3'b101: begin
                        if (imm12[11:5] == F7_BASE)     ctrl_c.aluop = ALU_SRL;
                        else if (imm12[11:5] == F7_ALT) ctrl_c.aluop = ALU_SRA;
                        else                            legal = 1'b0;
                    end
                    3'b110:  ctrl_c.aluop = ALU_OR;
                    default: ctrl_c.aluop = ALU_AND;
                endcase
            end
            OP_LUI: begin
                ctrl_c.alusrc   = SRC_IMM20;
                ctrl_c.regsel   = SEL_IMM20;
                ctrl_c.regwrite = 1'b1;
                ctrl_c.aluop    = ALU_AND;
            end
            OP_SYS: begin
                // CSRRW to an unmapped address is a legal no-op
                if (funct3 != F3_CSRRW) begin
                    legal = 1'b0;
                end else if (imm12 == CSR_GPIO_OUT) begin
                    ctrl_c.gpio_we = 1'b1;
                end else if (imm12 == CSR_GPIO_IN) begin
                    ctrl_c.regwrite = 1'b1;
                    ctrl_c.regsel   = SEL_GPIO;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            ctrl_c         = BUBBLE;
            ctrl_c.illegal = 1'b1;
            is_div_c       = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_unit_mc.sv
// Control unit top: EX control register plus the multi-cycle divide stall FSM.
module ctrl_unit_mc
    import ctrl_pkg::*;
#(
    parameter int unsigned DIV_LATENCY  = 34,
    parameter logic [11:0] CSR_GPIO_OUT = 12'hF00,
    parameter logic [11:0] CSR_GPIO_IN  = 12'hF02,
    parameter bit          ENABLE_M     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        flush,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [11:0] imm12,
    output logic [1:0]  alusrc_EX,
    output logic [3:0]  aluop_EX,
    output logic [1:0]  regsel_EX,
    output logic        regwrite_EX,
    output logic        GPIO_we,
    output logic        div_signed_EX,
    output logic        div_start,
    output logic        stall_FE,
    output logic        illegal_EX
);

    localparam int unsigned CNT_W    = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 2);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_bundle_t     ex_q, ex_d, dec_c;
    logic             is_div_c;
    logic             load_ex;
    logic             div_start_q, div_start_d;
    logic             stall_q, stall_d;

    ctrl_decode #(
        .CSR_GPIO_OUT (CSR_GPIO_OUT),
        .CSR_GPIO_IN  (CSR_GPIO_IN),
        .ENABLE_M     (ENABLE_M)
    ) u_decode (
        .op       (op),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm12    (imm12),
        .ctrl_c   (dec_c),
        .is_div_c (is_div_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ex_q        <= BUBBLE;
            div_start_q <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_q        <= ex_d;
            div_start_q <= div_start_d;
            stall_q     <= stall_d;
        end
    end

    // Next state, counter and EX bundle; DIV_DONE accepts the next instruction like IDLE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_d        = ex_q;
        div_start_d = 1'b0;
        load_ex     = 1'b0;
        case (state_q)
            ST_IDLE:     load_ex = 1'b1;
            ST_DIV_DONE: load_ex = 1'b1;
            ST_DIV_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    ex_d    = BUBBLE;
                end else if (cnt_q == '0) begin
                    state_d       = ST_DIV_DONE;
                    ex_d.regwrite = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ex_d    = BUBBLE;
            end
        endcase
        if (load_ex) begin
            state_d = ST_IDLE;
            if (flush || !instr_valid) begin
                ex_d = BUBBLE;
            end else begin
                ex_d = dec_c;
                if (is_div_c) begin
                    // Result write-back is deferred until the divider finishes
                    state_d       = ST_DIV_WAIT;
                    cnt_d         = CNT_LOAD;
                    div_start_d   = 1'b1;
                    ex_d.regwrite = 1'b0;
                end
            end
        end
        stall_d = (state_d == ST_DIV_WAIT);
    end

    assign alusrc_EX     = ex_q.alusrc;
    assign aluop_EX      = ex_q.aluop;
    assign regsel_EX     = ex_q.regsel;
    assign regwrite_EX   = ex_q.regwrite;
    assign GPIO_we       = ex_q.gpio_we;
    assign div_signed_EX = ex_q.div_signed;
    assign illegal_EX    = ex_q.illegal;
    assign div_start     = div_start_q;
    assign stall_FE      = stall_q;

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Scoreboard bench for ctrl_unit_mc: a timeline model predicts every EX cycle of two DUT instances.
module tb_ctrl_unit_mc;

    localparam int unsigned DIV_LAT = 4;

    logic        clk = 1'b0;
    logic        rst, instr_valid, flush;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;
    logic [11:0] imm12;

    logic [1:0] m_alusrc, m_regsel, n_alusrc, n_regsel;
    logic [3:0] m_aluop, n_aluop;
    logic m_regwrite, m_gpio_we, m_div_signed, m_div_start, m_stall, m_illegal;
    logic n_regwrite, n_gpio_we, n_div_signed, n_div_start, n_stall, n_illegal;

    typedef struct packed {
        logic [1:0] alusrc;
        logic [3:0] aluop;
        logic [1:0] regsel;
        logic       regwrite;
        logic       gpio_we;
        logic       div_signed;
        logic       div_start;
        logic       stall;
        logic       illegal;
    } frame_t;

    typedef struct {
        int     due;
        frame_t m;
        frame_t n;
    } exp_t;

    exp_t   exp_q[$];
    frame_t pend_q[$];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_pass = 0;
    frame_t act_m, act_n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ctrl_unit_mc #(.DIV_LATENCY(DIV_LAT), .CSR_GPIO_OUT(12'hF00), .CSR_GPIO_IN(12'hF02), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .flush(flush),
        .op(op), .funct3(funct3), .funct7(funct7), .imm12(imm12),
        .alusrc_EX(m_alusrc), .aluop_EX(m_aluop), .regsel_EX(m_regsel), .regwrite_EX(m_regwrite),
        .GPIO_we(m_gpio_we), .div_signed_EX(m_div_signed), .div_start(m_div_start),
        .stall_FE(m_stall), .illegal_EX(m_illegal)
    );

    ctrl_unit_mc #(.DIV_LATENCY(DIV_LAT), .CSR_GPIO_OUT(12'hF00), .CSR_GPIO_IN(12'hF02), .ENABLE_M(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .flush(flush),
        .op(op), .funct3(funct3), .funct7(funct7), .imm12(imm12),
        .alusrc_EX(n_alusrc), .aluop_EX(n_aluop), .regsel_EX(n_regsel), .regwrite_EX(n_regwrite),
        .GPIO_we(n_gpio_we), .div_signed_EX(n_div_signed), .div_start(n_div_start),
        .stall_FE(n_stall), .illegal_EX(n_illegal)
    );

    assign act_m = {m_alusrc, m_aluop, m_regsel, m_regwrite, m_gpio_we, m_div_signed, m_div_start, m_stall, m_illegal};
    assign act_n = {n_alusrc, n_aluop, n_regsel, n_regwrite, n_gpio_we, n_div_signed, n_div_start, n_stall, n_illegal};

    function automatic string fmt(input frame_t f);
        return $sformatf("src=%0d aluop=%0d sel=%0d rw=%0b gwe=%0b dsg=%0b dstart=%0b stall=%0b ill=%0b",
                         f.alusrc, f.aluop, f.regsel, f.regwrite, f.gpio_we, f.div_signed, f.div_start, f.stall, f.illegal);
    endfunction

    // Architectural decode straight from the ISA tables
    function automatic frame_t ref_decode(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [11:0] im, input bit en_m);
        logic [3:0] base_ops [8];
        logic [3:0] m_ops [8];
        logic [6:0] hi;
        frame_t fr;
        bit ok;
        base_ops = '{4'd3, 4'd8, 4'd12, 4'd13, 4'd2, 4'd9, 4'd1, 4'd0};
        m_ops    = '{4'd5, 4'd6, 4'd7, 4'd11, 4'd14, 4'd14, 4'd15, 4'd15};
        hi = im[11:5];
        fr = '0;
        ok = 1'b1;
        if (o == 7'h33) begin
            fr.regsel = 2'd2; fr.regwrite = 1'b1;
            if (f7 == 7'h00)                      fr.aluop = base_ops[f3];
            else if (f7 == 7'h20 && f3 == 3'd0)   fr.aluop = 4'd4;
            else if (f7 == 7'h20 && f3 == 3'd5)   fr.aluop = 4'd10;
            else if (f7 == 7'h01 && en_m) begin
                fr.aluop = m_ops[f3];
                fr.div_signed = (f3 == 3'd4 || f3 == 3'd6);
            end else ok = 1'b0;
        end else if (o == 7'h13) begin
            fr.alusrc = 2'd1; fr.regsel = 2'd2; fr.regwrite = 1'b1;
            if (f3 != 3'd5)        fr.aluop = base_ops[f3];
            else if (hi == 7'h00)  fr.aluop = 4'd9;
            else if (hi == 7'h20)  fr.aluop = 4'd10;
            else ok = 1'b0;
        end else if (o == 7'h37) begin
            fr.alusrc = 2'd2; fr.regsel = 2'd1; fr.regwrite = 1'b1;
        end else if (o == 7'h73 && f3 == 3'd1) begin
            if (im == 12'hF00) fr.gpio_we = 1'b1;
            else if (im == 12'hF02) begin fr.regwrite = 1'b1; fr.regsel = 2'd3; end
        end else ok = 1'b0;
        if (!ok) begin
            fr = '0;
            fr.illegal = 1'b1;
        end
        return fr;
    endfunction

    function automatic bit ref_is_div(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        return (o == 7'h33) && (f7 == 7'h01) && (f3 >= 3'd4);
    endfunction

    // Apply one cycle of inputs and queue what both instances must show after the next edge
    task automatic step(input bit r, input bit v, input bit f, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [11:0] im, output bit acc);
        frame_t dm, fr;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; instr_valid = v; flush = f; op = o; funct3 = f3; funct7 = f7; imm12 = im;
        dm = ref_decode(o, f3, f7, im, 1'b1);
        acc = 1'b0;
        e.due = cyc + 1;
        e.n = (r || !v || f) ? frame_t'(0) : ref_decode(o, f3, f7, im, 1'b0);
        if (r) begin
            pend_q.delete();
            e.m = '0;
            acc = 1'b1;
        end else if (pend_q.size() != 0) begin
            if (f) begin
                pend_q.delete();
                e.m = '0;
                acc = 1'b1;
            end else begin
                e.m = pend_q.pop_front();
            end
        end else begin
            acc = 1'b1;
            if (f || !v) begin
                e.m = '0;
            end else if (ref_is_div(o, f3, f7)) begin
                // Divide timeline: start frame, DIV_LAT-2 stalled frames, then the write-back frame
                fr = dm; fr.regwrite = 1'b0; fr.div_start = 1'b1; fr.stall = 1'b1;
                e.m = fr;
                fr.div_start = 1'b0;
                for (int i = 0; i < int'(DIV_LAT) - 2; i++) pend_q.push_back(fr);
                pend_q.push_back(dm);
            end else begin
                e.m = dm;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] im);
        bit a;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 1'b0, o, f3, f7, im, a);
            if (a) return;
        end
        n_checks++;
        $display("FAIL hold_accept: instruction op=%h not accepted within 64 cycles, required acceptance", o);
    endtask

    task automatic gen(output logic [6:0] o, output logic [2:0] f3, output logic [6:0] f7, output logic [11:0] im);
        int k;
        k  = $urandom_range(0, 9);
        f3 = 3'($urandom);
        f7 = 7'($urandom);
        im = 12'($urandom);
        o  = 7'($urandom);
        case (k)
            0, 1: begin o = 7'h33; f7 = 7'h00; end
            2:    begin o = 7'h33; f7 = 7'h20; end
            3, 4: begin o = 7'h33; f7 = 7'h01; end
            5:    o = 7'h13;
            6: begin
                o = 7'h13; f3 = 3'd5;
                case ($urandom_range(0, 2))
                    0: im[11:5] = 7'h00;
                    1: im[11:5] = 7'h20;
                    default: ;
                endcase
            end
            7: o = 7'h37;
            8: begin
                o = 7'h73;
                if ($urandom_range(0, 3) != 0) f3 = 3'd1;
                case ($urandom_range(0, 2))
                    0: im = 12'hF00;
                    1: im = 12'hF02;
                    default: ;
                endcase
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act_m === e.m) n_pass++;
            else $display("FAIL ex_bundle_m cyc=%0d got {%s} expected {%s}", cyc, fmt(act_m), fmt(e.m));
            n_checks++;
            if (act_n === e.n) n_pass++;
            else $display("FAIL ex_bundle_nm cyc=%0d got {%s} expected {%s}", cyc, fmt(act_n), fmt(e.n));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        bit v, f, r;
        bit have;
        logic [6:0]  o, f7;
        logic [2:0]  f3;
        logic [11:0] im;
        rst = 1'b1; instr_valid = 1'b0; flush = 1'b0; op = '0; funct3 = '0; funct7 = '0; imm12 = '0;
        step(1'b1, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 12'h000, a);
        step(1'b1, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 12'h000, a);

        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd0, 7'h00, 12'h000, a);   // add
        step(1'b0, 1'b1, 1'b0, 7'h13, 3'd5, 7'h00, 12'h405, a);   // srai
        step(1'b0, 1'b1, 1'b0, 7'h13, 3'd5, 7'h00, 12'h205, a);   // bad shift immediate
        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd4, 7'h01, 12'h000, a);   // div then stalled add
        hold(7'h33, 3'd0, 7'h00, 12'h000);
        step(1'b0, 1'b0, 1'b0, 7'h33, 3'd0, 7'h00, 12'h000, a);

        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd5, 7'h01, 12'h000, a);   // divu flushed mid-wait
        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd0, 7'h00, 12'h000, a);
        step(1'b0, 1'b1, 1'b1, 7'h33, 3'd0, 7'h00, 12'h000, a);
        hold(7'h33, 3'd0, 7'h00, 12'h000);

        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd6, 7'h01, 12'h000, a);   // rem aborted by reset
        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd0, 7'h00, 12'h000, a);
        step(1'b1, 1'b1, 1'b0, 7'h33, 3'd0, 7'h00, 12'h000, a);
        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd0, 7'h00, 12'h000, a);

        step(1'b0, 1'b1, 1'b0, 7'h73, 3'd1, 7'h00, 12'hF00, a);   // CSR writes and reads
        step(1'b0, 1'b1, 1'b0, 7'h73, 3'd1, 7'h00, 12'hF02, a);
        step(1'b0, 1'b1, 1'b0, 7'h73, 3'd1, 7'h00, 12'h123, a);
        step(1'b0, 1'b1, 1'b0, 7'h73, 3'd2, 7'h00, 12'hF00, a);
        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd0, 7'h01, 12'h000, a);   // mul
        step(1'b0, 1'b1, 1'b0, 7'h37, 3'd3, 7'h55, 12'hABC, a);   // lui
        step(1'b0, 1'b1, 1'b0, 7'h03, 3'd2, 7'h00, 12'h000, a);   // unknown opcode
        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd0, 7'h02, 12'h000, a);   // bad funct7

        step(1'b0, 1'b1, 1'b0, 7'h33, 3'd4, 7'h01, 12'h000, a);   // back-to-back divides
        hold(7'h33, 3'd7, 7'h01, 12'h000);
        hold(7'h33, 3'd0, 7'h20, 12'h000);

        have = 1'b0;
        o = '0; f3 = '0; f7 = '0; im = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!have) begin
                gen(o, f3, f7, im);
                have = 1'b1;
            end
            v = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 149) == 0);
            step(r, v, f, o, f3, f7, im, a);
            if (a) have = 1'b0;
        end

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected frames left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
